// File: rtl/signed_down_reload_counter.sv
// Signed W-bit down counter with load, enable and wrap/saturate/one-shot/auto-reload
// terminal-count modes, gated by an IDLE/RUN/HALT FSM.
module signed_down_reload_counter #(
  parameter int W = 4
) (
  input  logic         C,
  input  logic         CLR,
  input  logic         EN,
  input  logic         LD,
  input  logic [W-1:0] D,
  input  logic [1:0]   MODE,
  output logic [W-1:0] Q,
  output logic         ZERO,
  output logic         TC,
  output logic         DONE,
  output logic         BUSY
);
  localparam logic signed [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic signed [W-1:0] ZRO = '0;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t              r_state;
  logic signed [W-1:0] r_q, r_rld;
  logic                r_tc, r_done, r_busy;

  logic signed [W-1:0] w_dec, w_wrap;
  logic                w_at_min;

  assign w_dec    = r_q - ONE;
  assign w_at_min = (r_q == MIN);
  assign w_wrap   = w_at_min ? MAX : w_dec;

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_rld   <= '0;
      r_tc    <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      // TC is a single-cycle pulse; only a wrap or reload below re-raises it
      r_tc <= 1'b0;
      if (LD) begin
        r_q     <= $signed(D);
        r_rld   <= $signed(D);
        r_state <= RUN;
        r_done  <= 1'b0;
        r_busy  <= 1'b1;
      end else if (r_state == RUN && EN) begin
        unique case (MODE)
          2'b00: begin
            r_q  <= w_wrap;
            r_tc <= w_at_min;
          end
          2'b01: begin
            if (w_at_min) begin
              r_state <= HALT;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_q <= w_dec;
            end
          end
          2'b10: begin
            if (r_q > ONE) begin
              r_q <= w_dec;
            end else begin
              // Q==1 lands on zero as it halts; Q<=0 just halts in place
              if (r_q == ONE) r_q <= '0;
              r_state <= HALT;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            if (r_q == ZRO) begin
              r_q  <= r_rld;
              r_tc <= 1'b1;
            end else begin
              r_q  <= w_wrap;
              r_tc <= w_at_min;
            end
          end
        endcase
      end
    end
  end

  assign Q    = r_q;
  assign ZERO = (r_q == ZRO);
  assign TC   = r_tc;
  assign DONE = r_done;
  assign BUSY = r_busy;
endmodule

// File: tb/tb_signed_down_reload_counter.sv
// Scoreboard bench: a behavioural integer model predicts each edge's outputs,
// pushes them on drive, and they are popped and compared after the edge.
module tb_signed_down_reload_counter;
  localparam int W   = 4;
  localparam int MIN = -(1 << (W-1));
  localparam int MAX = (1 << (W-1)) - 1;

  logic         C = 1'b0, CLR = 1'b1, EN = 1'b0, LD = 1'b0;
  logic [W-1:0] D = '0;
  logic [1:0]   MODE = 2'b00;
  logic [W-1:0] Q;
  logic         ZERO, TC, DONE, BUSY;

  signed_down_reload_counter #(.W(W)) dut (
    .C(C), .CLR(CLR), .EN(EN), .LD(LD), .D(D), .MODE(MODE),
    .Q(Q), .ZERO(ZERO), .TC(TC), .DONE(DONE), .BUSY(BUSY)
  );

  always #5 C = ~C;

  typedef struct {
    int q;
    bit zero, tc, done, busy;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0, n_err = 0;

  // model state: 0 idle, 1 run, 2 halt
  int ms = 0, mq = 0, mrld = 0;
  bit mtc = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int qs();
    return int'($signed(Q));
  endfunction

  task automatic model_reset();
    ms = 0; mq = 0; mrld = 0; mtc = 0;
  endtask

  task automatic model_edge(input bit ld, input bit en, input int d, input bit [1:0] mode);
    mtc = 0;
    if (ld) begin
      mq = d; mrld = d; ms = 1;
    end else if (ms == 1 && en) begin
      case (mode)
        2'b00: if (mq == MIN) begin mq = MAX; mtc = 1; end else mq = mq - 1;
        2'b01: if (mq == MIN) ms = 2; else mq = mq - 1;
        2'b10: if (mq > 1) mq = mq - 1;
               else begin if (mq == 1) mq = 0; ms = 2; end
        default:
          if (mq == 0) begin mq = mrld; mtc = 1; end
          else if (mq == MIN) begin mq = MAX; mtc = 1; end
          else mq = mq - 1;
      endcase
    end
  endtask

  task automatic step(input bit ld, input bit en, input int d, input bit [1:0] mode);
    exp_t e;
    @(negedge C);
    LD = ld; EN = en; D = d[W-1:0]; MODE = mode;
    model_edge(ld, en, d, mode);
    e.q = mq; e.zero = (mq == 0); e.tc = mtc; e.done = (ms == 2); e.busy = (ms == 1);
    sb.push_back(e);
    @(posedge C);
    #1;
    e = sb.pop_front();
    chk("q",    qs(),      e.q);
    chk("zero", int'(ZERO), int'(e.zero));
    chk("tc",   int'(TC),   int'(e.tc));
    chk("done", int'(DONE), int'(e.done));
    chk("busy", int'(BUSY), int'(e.busy));
  endtask

  initial begin
    #2;
    chk("rst_q",    qs(),       0);
    chk("rst_zero", int'(ZERO), 1);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_done", int'(DONE), 0);
    @(negedge C); CLR = 1'b0;
    model_reset();

    // idle ignores EN
    step(0, 1, 0, 2'b00);
    // asynchronous clear mid-count
    step(1, 0, 5, 2'b00);
    step(0, 0, 0, 2'b00);
    @(negedge C); #2 CLR = 1'b1; #1;
    chk("clr_q",    qs(),       0);
    chk("clr_zero", int'(ZERO), 1);
    chk("clr_busy", int'(BUSY), 0);
    chk("clr_done", int'(DONE), 0);
    #1 CLR = 1'b0;
    model_reset();
    repeat (2) step(0, 1, 0, 2'b00);

    // wrap: -7, -8, 7 with TC on 7
    step(1, 0, -6, 2'b00);
    repeat (3) step(0, 1, 0, 2'b00);
    chk("wrap_q", qs(), 7);
    // saturate: -8, -8 (halt), -8
    step(1, 0, -7, 2'b01);
    repeat (3) step(0, 1, 0, 2'b01);
    chk("sat_done", int'(DONE), 1);
    // one-shot from 3 and from -2
    step(1, 0, 3, 2'b10);
    repeat (5) step(0, 1, 0, 2'b10);
    step(1, 0, -2, 2'b10);
    repeat (2) step(0, 1, 0, 2'b10);
    chk("os_neg_q", qs(), -2);
    // auto-reload from 2, then RLD=0
    step(1, 0, 2, 2'b11);
    repeat (6) step(0, 1, 0, 2'b11);
    step(1, 0, 0, 2'b11);
    repeat (3) step(0, 1, 0, 2'b11);
    // LD beats EN, then hold
    step(1, 0, 4, 2'b00);
    step(1, 1, -3, 2'b00);
    step(0, 0, 0, 2'b00);
    chk("ldpri_q", qs(), -3);
    // mode change mid-run
    step(1, 0, 1, 2'b11);
    step(0, 1, 0, 2'b11);
    step(0, 1, 0, 2'b00);
    step(0, 1, 0, 2'b10);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, MAX - MIN)) + MIN, 2'($urandom_range(0, 3)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1);
  end
endmodule

// File: doc/signed_down_reload_counter.md
# signed_down_reload_counter

Parameterised signed down counter with synchronous load, count enable and four terminal-count modes: wrap, saturate, one-shot and auto-reload. It is the counting-down counterpart of the team's signed up counter. It serves as a programmable interval timer or event down-counter in the same designs. A three-state FSM (IDLE/RUN/HALT) gates counting and reports completion.

## Interface
- W, default 4: counter width in bits; Q, D and the internal reload register are two's-complement signed [W-1:0]; MIN = -2^(W-1), MAX = 2^(W-1)-1.
- C  input  1  clock; all state changes on the rising edge except reset.
- CLR  input  1  reset, asynchronous, active-high.
- EN  input  1  count enable, sampled on the rising edge of C.
- LD  input  1  synchronous load; has priority over EN.
- D  input  W  signed load value; also written into the reload register RLD.
- MODE  input  2  00 wrap, 01 saturate, 10 one-shot, 11 auto-reload; sampled every edge.
- Q  output  W  signed count, registered.
- ZERO  output  1  combinational, equal to (Q == 0).
- TC  output  1  registered one-cycle pulse on wrap or reload.
- DONE  output  1  registered level, high while in HALT.
- BUSY  output  1  registered level, high while in RUN.

## Operation
- FSM states: IDLE, RUN, HALT.
- Reset state is IDLE.
- In IDLE, Q holds and EN is ignored. Only LD leaves IDLE.
- In HALT, Q holds, DONE=1 and EN is ignored. Only LD leaves HALT.
- LD=1 in any state:
  - Q<=D, RLD<=D, state<=RUN, TC<=0, DONE<=0.
  - No decrement occurs in the load cycle, even if EN=1.
- RUN with EN=0: Q holds, TC<=0.
- RUN with EN=1, behaviour by MODE:
  - 00 wrap: Q<=Q-1. If Q==MIN, then Q<=MAX and TC<=1.
  - 01 saturate: if Q>MIN, Q<=Q-1. If Q==MIN, Q holds and state<=HALT. Q reaching MIN does not halt by itself; the halt happens on the next enabled edge.
  - 10 one-shot:
    - If Q>1, Q<=Q-1.
    - If Q==1, Q<=0 and state<=HALT on the same edge.
    - If Q<=0, Q holds and state<=HALT.
  - 11 auto-reload:
    - If Q==0, Q<=RLD and TC<=1.
    - Otherwise decrement, applying the mode-00 wrap rule at MIN, which also pulses TC.
    - If RLD==0, Q stays 0 and TC is high every enabled cycle.
- Arithmetic is W-bit two's complement. Every decision uses a signed compare; no unsigned comparisons.
- TC is cleared on every edge on which no wrap or reload occurs.
- A MODE change mid-run takes effect at the next enabled edge. Q is not modified by the change itself.
- CLR asserted at any time, including mid-count or during a load edge:
  - Immediately forces Q=0, RLD=0, IDLE, TC=0, DONE=0, BUSY=0, and therefore ZERO=1.
  - Release of CLR leaves the block in IDLE until LD.

## Timing
- Load latency: Q shows D after the LD edge, with BUSY=1 in the same cycle.
- Decrement latency: one edge per enabled cycle; throughput is 1 count per clock.
- TC, DONE and BUSY update on the same edge as the Q value that caused them.
- ZERO follows Q combinationally with no added cycle.
- CLR is asynchronous and takes effect without a clock edge.
- CLR deassertion is assumed synchronised externally to C.

## Test plan
- W=4, Q=5 in RUN, CLR pulsed between clock edges -> Q=0, ZERO=1, BUSY=0, DONE=0 before the next edge; following EN-only edges leave Q=0.
- MODE=00, LD D=-6, then EN for 3 edges -> Q=-7, -8, 7; TC=1 only in the cycle Q=7; BUSY stays 1.
- MODE=01, LD D=-7, then EN for 3 edges -> Q=-8, -8, -8; DONE=1 and BUSY=0 from the second EN edge; TC never asserts.
- MODE=10:
  - LD D=3, then EN -> Q=2, 1, 0, with DONE=1 on the edge Q becomes 0; further EN edges keep Q=0.
  - LD D=-2, then EN -> Q=-2, DONE=1.
- MODE=11, LD D=2, then EN for 6 edges -> Q=1, 0, 2, 1, 0, 2; TC=1 exactly in the cycles showing 2 after reload.
- In RUN at Q=4, with LD=1, EN=1 and D=-3 on the same edge -> Q=-3, no decrement; next edge with EN=0 -> Q holds at -3.
